dac_spi_sched: RTL and testbench

//  Trigger-driven scheduler that sequences per-channel DAC SPI transfers in the SPI clock domain.
//  - Sits after spi_cfg_sync and consumes its *_stable outputs: spi_en, dac_divider, trig_lockout.
//  - On each accepted trigger it snapshots all channel words and issues one transfer per channel.
//  - Transfers are paced by dac_divider; re-triggering is blocked for trig_lockout cycles.

---
 rtl/dac_spi_sched.sv | 208 ++++++++++++++++++++
 tb/tb_dac_spi_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_sched.sv
`default_nettype none
// ============================================================================
// Module      : dac_spi_sched
// Description : Trigger-driven scheduler sequencing per-channel DAC SPI
//               transfers. Optional watchdog/FAULT under DAC_SPI_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_spi_sched #(
   parameter int N_CH        = 8,
   parameter int DATA_W      = 16,
   parameter int CH_W        = 3,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   spi_en,
   input  logic [15:0]            dac_divider,
   input  logic [31:0]            trig_lockout,
   input  logic                   trig,
   input  logic [N_CH*DATA_W-1:0] ch_data,
   input  logic                   spi_busy,
   input  logic                   spi_done,
   output logic                   spi_start,
   output logic [CH_W-1:0]        spi_ch,
   output logic [DATA_W-1:0]      spi_data,
   output logic                   sched_busy,
   output logic [15:0]            trig_missed,
   output logic                   xfer_timeout
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_XFER    = 3'd2,
      ST_LOCKOUT = 3'd3,
      ST_FAULT   = 3'd4
   } state_t;

   localparam logic [CH_W-1:0] LAST_IDX = CH_W'(N_CH - 1);

   if (N_CH < 1 || CH_W < 1 || TIMEOUT_CYC < 1 || (1 << CH_W) < N_CH) begin : g_param_check
      $error("dac_spi_sched: invalid N_CH/CH_W/TIMEOUT_CYC");
   end

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  shadow_q [N_CH];
   logic [DATA_W-1:0]  shadow_d [N_CH];
   logic [15:0]        div_ld_q, div_ld_d;
   logic [15:0]        div_cnt_q, div_cnt_d;
   logic [31:0]        lock_cnt_q, lock_cnt_d;
   logic [CH_W-1:0]    idx_q, idx_d;
   logic               outst_q, outst_d;
   logic               spi_start_q, spi_start_d;
   logic [CH_W-1:0]    spi_ch_q, spi_ch_d;
   logic [DATA_W-1:0]  spi_data_q, spi_data_d;
   logic [15:0]        trig_missed_q, trig_missed_d;
   logic               accept;
   logic               done_ok;
   logic               start_ok;

`ifdef DAC_SPI_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
   logic               xfer_timeout_q, xfer_timeout_d;
`endif

   // A done coinciding with a start pulse belongs to the previous transfer.
   assign accept   = (state_q == ST_ARMED) && trig && spi_en;
   assign done_ok  = spi_done && outst_q && !spi_start_q;
   assign start_ok = !spi_busy && (div_cnt_q == 16'd0) && !outst_q;

   always_comb begin
      state_d       = state_q;
      shadow_d      = shadow_q;
      div_ld_d      = div_ld_q;
      div_cnt_d     = (div_cnt_q != 16'd0) ? div_cnt_q - 16'd1 : 16'd0;
      lock_cnt_d    = (lock_cnt_q != 32'd0) ? lock_cnt_q - 32'd1 : 32'd0;
      idx_d         = idx_q;
      outst_d       = outst_q;
      spi_start_d   = 1'b0;
      spi_ch_d      = spi_ch_q;
      spi_data_d    = spi_data_q;
      trig_missed_d = trig_missed_q;
`ifdef DAC_SPI_SCHED_TIMEOUT_EN
      wd_cnt_d       = outst_q ? wd_cnt_q + 1'b1 : wd_cnt_q;
      xfer_timeout_d = xfer_timeout_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (spi_en) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (trig) begin
               state_d    = ST_XFER;
               for (int k = 0; k < N_CH; k++) shadow_d[k] = ch_data[k*DATA_W +: DATA_W];
               div_ld_d   = (dac_divider == 16'd0) ? 16'd1 : dac_divider;
               div_cnt_d  = 16'd0;
               lock_cnt_d = trig_lockout;
               idx_d      = '0;
               outst_d    = 1'b0;
            end
         end
         ST_XFER: begin
            if (done_ok) begin
               outst_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = (lock_cnt_q > 32'd1) ? ST_LOCKOUT : ST_ARMED;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else if (start_ok) begin
               spi_start_d = 1'b1;
               spi_ch_d    = idx_q;
               spi_data_d  = shadow_q[idx_q];
               outst_d     = 1'b1;
               div_cnt_d   = div_ld_q - 16'd1;
`ifdef DAC_SPI_SCHED_TIMEOUT_EN
               wd_cnt_d    = '0;
            end else if (outst_q && wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) begin
               xfer_timeout_d = 1'b1;
               outst_d        = 1'b0;
               state_d        = ST_FAULT;
`endif
            end
         end
         ST_LOCKOUT: begin
            if (lock_cnt_q <= 32'd1) state_d = ST_ARMED;
         end
`ifdef DAC_SPI_SCHED_TIMEOUT_EN
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      if (trig && !accept && trig_missed_q != 16'hFFFF)
         trig_missed_d = trig_missed_q + 16'd1;

      // Disable wins over everything except the sticky status outputs.
      if (!spi_en) begin
         state_d     = ST_IDLE;
         shadow_d    = '{default: '0};
         div_ld_d    = 16'd0;
         div_cnt_d   = 16'd0;
         lock_cnt_d  = 32'd0;
         idx_d       = '0;
         outst_d     = 1'b0;
         spi_start_d = 1'b0;
`ifdef DAC_SPI_SCHED_TIMEOUT_EN
         wd_cnt_d    = '0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         shadow_q      <= '{default: '0};
         div_ld_q      <= 16'd0;
         div_cnt_q     <= 16'd0;
         lock_cnt_q    <= 32'd0;
         idx_q         <= '0;
         outst_q       <= 1'b0;
         spi_start_q   <= 1'b0;
         spi_ch_q      <= '0;
         spi_data_q    <= '0;
         trig_missed_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         shadow_q      <= shadow_d;
         div_ld_q      <= div_ld_d;
         div_cnt_q     <= div_cnt_d;
         lock_cnt_q    <= lock_cnt_d;
         idx_q         <= idx_d;
         outst_q       <= outst_d;
         spi_start_q   <= spi_start_d;
         spi_ch_q      <= spi_ch_d;
         spi_data_q    <= spi_data_d;
         trig_missed_q <= trig_missed_d;
      end
   end

`ifdef DAC_SPI_SCHED_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt_q       <= '0;
         xfer_timeout_q <= 1'b0;
      end else begin
         wd_cnt_q       <= wd_cnt_d;
         xfer_timeout_q <= xfer_timeout_d;
      end
   end
   assign xfer_timeout = xfer_timeout_q;
`else
   assign xfer_timeout = 1'b0;
`endif

   assign spi_start   = spi_start_q;
   assign spi_ch      = spi_ch_q;
   assign spi_data    = spi_data_q;
   assign sched_busy  = (state_q == ST_XFER) || (state_q == ST_LOCKOUT);
   assign trig_missed = trig_missed_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_spi_sched
// Description : Directed self-checking bench for dac_spi_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_spi_sched;
   localparam int N_CH   = 8;
   localparam int DATA_W = 16;
   localparam int CH_W   = 3;
   localparam int TO_CYC = 1024;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   spi_en = 1'b0;
   logic [15:0]            dac_divider = 16'd10;
   logic [31:0]            trig_lockout = 32'd0;
   logic                   trig = 1'b0;
   logic [N_CH*DATA_W-1:0] ch_data = '0;
   logic                   spi_busy = 1'b0;
   logic                   spi_done = 1'b0;
   logic                   spi_start;
   logic [CH_W-1:0]        spi_ch;
   logic [DATA_W-1:0]      spi_data;
   logic                   sched_busy;
   logic [15:0]            trig_missed;
   logic                   xfer_timeout;

   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;
   bit eng_en = 1'b1;
   int done_dly = 0;
   int st_cyc[$];
   int st_ch[$];
   int st_dat[$];
   logic [DATA_W-1:0] snap [N_CH];

   dac_spi_sched #(
      .N_CH(N_CH), .DATA_W(DATA_W), .CH_W(CH_W), .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk(clk), .rst(rst), .spi_en(spi_en), .dac_divider(dac_divider),
      .trig_lockout(trig_lockout), .trig(trig), .ch_data(ch_data),
      .spi_busy(spi_busy), .spi_done(spi_done), .spi_start(spi_start),
      .spi_ch(spi_ch), .spi_data(spi_data), .sched_busy(sched_busy),
      .trig_missed(trig_missed), .xfer_timeout(xfer_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SPI engine model: done 3 cycles after each start; logs every start.
   always @(negedge clk) begin
      spi_done = 1'b0;
      if (spi_start) begin
         done_dly = 3;
         st_cyc.push_back(cyc);
         st_ch.push_back(int'(spi_ch));
         st_dat.push_back(int'(spi_data));
      end else if (done_dly > 0) begin
         done_dly--;
         if (done_dly == 0 && eng_en) spi_done = 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_snap(input logic [15:0] base);
      for (int k = 0; k < N_CH; k++) begin
         snap[k] = base + 16'(k * 16'h0111);
         ch_data[k*DATA_W +: DATA_W] = snap[k];
      end
   endtask

   task automatic clear_log;
      st_cyc.delete();
      st_ch.delete();
      st_dat.delete();
   endtask

   task automatic pulse_trig(output int t);
      trig = 1'b1;
      t = cyc;
      @(negedge clk);
      trig = 1'b0;
   endtask

   task automatic wait_starts(input int n, input int budget);
      int k = 0;
      while (st_cyc.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("start_count", st_cyc.size(), n);
   endtask

   task automatic wait_pulse(input int budget);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!spi_start && k < budget);
      check("start_seen", {31'd0, spi_start}, 32'd1);
   endtask

   task automatic check_frame(input int t_trig, input int gap);
      check("frame_len", st_cyc.size(), N_CH);
      if (st_cyc.size() > 0) check("latency", st_cyc[0], t_trig + 2);
      for (int k = 0; k < st_cyc.size() && k < N_CH; k++) begin
         check($sformatf("ch%0d", k), st_ch[k], k);
         check($sformatf("data%0d", k), st_dat[k], {16'd0, snap[k]});
         if (gap > 0 && k > 0) check($sformatf("gap%0d", k), st_cyc[k] - st_cyc[k-1], gap);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int t, t0, t1, s;
      tick(2);
      check("rst_start", {31'd0, spi_start}, 0);
      check("rst_ch", {29'd0, spi_ch}, 0);
      check("rst_data", {16'd0, spi_data}, 0);
      check("rst_busy", {31'd0, sched_busy}, 0);
      check("rst_missed", {16'd0, trig_missed}, 0);
      check("rst_timeout", {31'd0, xfer_timeout}, 0);
      rst = 1'b0;
      spi_en = 1'b1;
      tick(3);

      // Basic frame, divider 10, data scrambled after capture.
      dac_divider = 16'd10;
      trig_lockout = 32'd0;
      load_snap(16'hA000);
      clear_log();
      pulse_trig(t);
      ch_data = ~ch_data;
      wait_starts(8, 200);
      tick(10);
      check_frame(t, 10);
      check("idle_busy", {31'd0, sched_busy}, 0);
      check("missed0", {16'd0, trig_missed}, 0);

      // Divider 0 behaves as 1: pacing limited by done turnaround.
      dac_divider = 16'd0;
      load_snap(16'h1234);
      clear_log();
      pulse_trig(t);
      wait_starts(8, 200);
      tick(10);
      check_frame(t, 5);

      // spi_busy held for 50 cycles after the 2nd start.
      dac_divider = 16'd10;
      load_snap(16'h5A00);
      clear_log();
      pulse_trig(t);
      wait_pulse(50);
      wait_pulse(50);
      spi_busy = 1'b1;
      tick(50);
      spi_busy = 1'b0;
      wait_starts(8, 300);
      tick(10);
      check_frame(t, -1);
      if (st_cyc.size() >= 4) begin
         check("busy_gap", st_cyc[2] - st_cyc[1], 51);
         check("post_busy_gap", st_cyc[3] - st_cyc[2], 10);
      end

      // Lockout 200: retrigger inside window missed, at boundary accepted.
      trig_lockout = 32'd200;
      load_snap(16'h0F00);
      clear_log();
      pulse_trig(t0);
      while (cyc < t0 + 150) tick(1);
      check("lock_busy", {31'd0, sched_busy}, 1);
      trig = 1'b1;
      tick(1);
      trig = 1'b0;
      check("missed1", {16'd0, trig_missed}, 1);
      while (cyc < t0 + 200) tick(1);
      trig = 1'b1;
      tick(1);
      check("missed2", {16'd0, trig_missed}, 2);
      t1 = cyc;
      load_snap(16'h2200);
      clear_log();
      tick(1);
      trig = 1'b0;
      wait_starts(8, 200);
      tick(10);
      check_frame(t1, 10);
      check("missed2_hold", {16'd0, trig_missed}, 2);
      tick(150);

      // Drop spi_en after the 3rd start.
      trig_lockout = 32'd0;
      load_snap(16'h3300);
      clear_log();
      pulse_trig(t);
      wait_pulse(50);
      wait_pulse(50);
      wait_pulse(50);
      spi_en = 1'b0;
      tick(1);
      check("dis_busy", {31'd0, sched_busy}, 0);
      check("dis_start", {31'd0, spi_start}, 0);
      tick(30);
      check("dis_count", st_cyc.size(), 3);
      spi_en = 1'b1;
      tick(2);
      load_snap(16'h7700);
      clear_log();
      pulse_trig(t);
      wait_starts(8, 200);
      tick(10);
      check_frame(t, 10);

      // Asynchronous reset mid-transfer.
      load_snap(16'h4400);
      clear_log();
      pulse_trig(t);
      wait_pulse(50);
      wait_pulse(50);
      rst = 1'b1;
      tick(1);
      check("mrst_start", {31'd0, spi_start}, 0);
      check("mrst_ch", {29'd0, spi_ch}, 0);
      check("mrst_data", {16'd0, spi_data}, 0);
      check("mrst_busy", {31'd0, sched_busy}, 0);
      check("mrst_missed", {16'd0, trig_missed}, 0);
      rst = 1'b0;
      clear_log();
      tick(40);
      check("mrst_quiet", st_cyc.size(), 0);
      load_snap(16'h6600);
      pulse_trig(t);
      wait_starts(8, 200);
      tick(10);
      check_frame(t, 10);

`ifdef DAC_SPI_SCHED_TIMEOUT_EN
      eng_en = 1'b0;
      load_snap(16'h9900);
      clear_log();
      pulse_trig(t);
      wait_pulse(10);
      s = cyc;
      while (cyc < s + TO_CYC - 1) tick(1);
      check("to_pre", {31'd0, xfer_timeout}, 0);
      tick(1);
      check("to_set", {31'd0, xfer_timeout}, 1);
      check("fault_busy", {31'd0, sched_busy}, 0);
      tick(50);
      check("fault_quiet", st_cyc.size(), 1);
      spi_en = 1'b0;
      tick(1);
      spi_en = 1'b1;
      eng_en = 1'b1;
      tick(2);
      clear_log();
      pulse_trig(t);
      wait_starts(8, 200);
      tick(10);
      check_frame(t, 10);
      check("to_sticky", {31'd0, xfer_timeout}, 1);
`else
      check("to_tied", {31'd0, xfer_timeout}, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
